// File: rtl/axi_tdd_frame_seq_if.sv
// Interface bundle for the TDD frame sequencer.
// Carries the enable, sync and configuration inputs and the status outputs.
// The master modport is the controller side that drives enable, sync and configuration.
// The slave modport is the sequencer side.
interface axi_tdd_frame_seq_if #(
    parameter int CNT_WIDTH   = 32,
    parameter int BURST_WIDTH = 32
);
    logic                   tdd_enable;
    logic                   tdd_sync;
    logic [CNT_WIDTH-1:0]   asy_startup_delay;
    logic [CNT_WIDTH-1:0]   asy_frame_length;
    logic [BURST_WIDTH-1:0] asy_burst_count;

    logic [1:0]             tdd_cstate;
    logic [CNT_WIDTH-1:0]   tdd_counter;
    logic [BURST_WIDTH-1:0] tdd_frame_idx;
    logic                   tdd_frame_start;
    logic                   tdd_endof_frame;
    logic                   tdd_burst_done;

    modport master (
        output tdd_enable, tdd_sync, asy_startup_delay, asy_frame_length, asy_burst_count,
        input  tdd_cstate, tdd_counter, tdd_frame_idx, tdd_frame_start, tdd_endof_frame,
               tdd_burst_done
    );

    modport slave (
        input  tdd_enable, tdd_sync, asy_startup_delay, asy_frame_length, asy_burst_count,
        output tdd_cstate, tdd_counter, tdd_frame_idx, tdd_frame_start, tdd_endof_frame,
               tdd_burst_done
    );
endinterface

// File: rtl/axi_tdd_frame_seq.sv
// TDD frame sequencer.
// The sequencer arms on a rising edge of tdd_enable and waits for tdd_sync.
// It then counts out the startup delay and runs a programmed number of frames.
// A burst count of 0 runs frames until enable drops.
// Optional macro AXI_TDD_FRAME_SEQ_RESYNC_EN: a sync seen while WAITING or RUNNING
// restarts frame timing at counter 0 and leaves frame_idx unchanged.
//
// Signalling: there is no valid/ready handshake on this block.
//   - tdd_enable is a level. Arming needs a low-to-high edge. Dropping the level
//     aborts the sequencer from any state on the next clock.
//   - tdd_sync is a single-cycle pulse, sampled on the clock edge.
//   - asy_* are quasi-static. They are sampled only on the cycle the sequencer leaves IDLE.
//   - All outputs are decoded from registers only, so no input reaches an output
//     within the same cycle.
module axi_tdd_frame_seq #(
    parameter int CNT_WIDTH   = 32,
    parameter int BURST_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_tdd_frame_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WAITING = 2'd2,
        ST_RUNNING = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [CNT_WIDTH-1:0]   counter;
    logic [BURST_WIDTH-1:0] frame_idx;
    logic                   enable_q;
    logic [CNT_WIDTH-1:0]   delay_q;
    logic [CNT_WIDTH-1:0]   length_q;
    logic [BURST_WIDTH-1:0] burst_q;

    logic frame_last;
    logic burst_last;
    logic resync;

    // Frame position decode. A length of 0 wraps to all ones, which gives a
    // frame of 2^CNT_WIDTH cycles.
    assign frame_last = (state == ST_RUNNING) && (counter == length_q - CNT_ONE);
    assign burst_last = (burst_q != '0) && (frame_idx == burst_q - BURST_ONE);

`ifdef AXI_TDD_FRAME_SEQ_RESYNC_EN
    assign resync = bus.tdd_sync;
`else
    assign resync = 1'b0;
`endif

    // Sequencer state, counter, frame index, config copies and enable edge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            counter   <= '0;
            frame_idx <= '0;
            enable_q  <= 1'b0;
            delay_q   <= '0;
            length_q  <= '0;
            burst_q   <= '0;
        end else begin
            enable_q <= bus.tdd_enable;
            if (!bus.tdd_enable) begin
                // An enable drop aborts from any state and overrides sync and frame end.
                state     <= ST_IDLE;
                counter   <= '0;
                frame_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!enable_q) begin
                            state     <= ST_ARMED;
                            counter   <= '0;
                            frame_idx <= '0;
                            delay_q   <= bus.asy_startup_delay;
                            length_q  <= bus.asy_frame_length;
                            burst_q   <= bus.asy_burst_count;
                        end
                    end
                    ST_ARMED: begin
                        counter   <= '0;
                        frame_idx <= '0;
                        if (bus.tdd_sync) begin
                            state <= (delay_q != '0) ? ST_WAITING : ST_RUNNING;
                        end
                    end
                    ST_WAITING: begin
                        if (resync || (counter == delay_q - CNT_ONE)) begin
                            state   <= ST_RUNNING;
                            counter <= '0;
                        end else begin
                            counter <= counter + CNT_ONE;
                        end
                    end
                    ST_RUNNING: begin
                        if (frame_last) begin
                            // End of frame is handled before any coincident resync.
                            // A resync on this cycle would also restart at counter 0.
                            counter <= '0;
                            if (burst_last) begin
                                state     <= ST_IDLE;
                                frame_idx <= '0;
                            end else begin
                                frame_idx <= frame_idx + BURST_ONE;
                            end
                        end else if (resync) begin
                            counter <= '0;
                        end else begin
                            counter <= counter + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tdd_cstate      = state;
    assign bus.tdd_counter     = counter;
    assign bus.tdd_frame_idx   = frame_idx;
    assign bus.tdd_frame_start = (state == ST_RUNNING) && (counter == '0);
    assign bus.tdd_endof_frame = frame_last;
    assign bus.tdd_burst_done  = frame_last && burst_last;

endmodule

// File: tb/tb_axi_tdd_frame_seq.sv
// Testbench for axi_tdd_frame_seq.
// Each cycle the bench drives one input record and queues the output it expects
// after the next clock edge. It compares on the following falling edge.
module tb_axi_tdd_frame_seq;

    localparam int CW = 32;
    localparam int BW = 32;
    localparam int W  = 2 + CW + BW + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_tdd_frame_seq_if #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) bus ();

    axi_tdd_frame_seq #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    logic [CW-1:0] cfg_delay;
    logic [CW-1:0] cfg_length;
    logic [BW-1:0] cfg_burst;

    typedef struct {
        logic          en;
        logic          sync;
        logic [CW-1:0] dl;
        logic [CW-1:0] ln;
        logic [BW-1:0] bu;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        logic [BW-1:0] idx;
        logic          fs;
        logic          eof;
        logic          bd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic en, input logic sync, input int dl, input int ln,
                                input int bu, input logic [1:0] st, input int cnt, input int idx,
                                input logic fs, input logic eof, input logic bd);
        vec_t v;
        v.en = en; v.sync = sync;
        v.dl = CW'(dl); v.ln = CW'(ln); v.bu = BW'(bu);
        v.st = st; v.cnt = CW'(cnt); v.idx = BW'(idx);
        v.fs = fs; v.eof = eof; v.bd = bd;
        tbl.push_back(v);
    endfunction

    task automatic check_out();
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_underflow: no expected entry queued");
            return;
        end
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {bus.tdd_cstate, bus.tdd_counter, bus.tdd_frame_idx,
                 bus.tdd_frame_start, bus.tdd_endof_frame, bus.tdd_burst_done};
        if (act_v === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d cnt=%0d idx=%0d fs=%b eof=%b bd=%b, expected st=%0d cnt=%0d idx=%0d fs=%b eof=%b bd=%b",
                     nm, act_v[W-1 -: 2], act_v[CW+BW+2 -: CW], act_v[BW+2 -: BW],
                     act_v[2], act_v[1], act_v[0],
                     exp_v[W-1 -: 2], exp_v[CW+BW+2 -: CW], exp_v[BW+2 -: BW],
                     exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Drive one cycle of inputs from the falling edge, queue the expectation and
    // compare on the next falling edge.
    task automatic cyc(input logic r, input logic e, input logic s, input logic [1:0] st,
                       input int cnt, input int idx, input logic fs, input logic eof,
                       input logic bd, input string nm);
        rst                   = r;
        bus.tdd_enable        = e;
        bus.tdd_sync          = s;
        bus.asy_startup_delay = cfg_delay;
        bus.asy_frame_length  = cfg_length;
        bus.asy_burst_count   = cfg_burst;
        exp_q.push_back({st, CW'(cnt), BW'(idx), fs, eof, bd});
        name_q.push_back(nm);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        // ---- table: basic burst (delay 3, length 5, burst 2) ----
        add(1, 0, 3, 5, 2, S_ARM,  0, 0, 0, 0, 0);
        add(1, 1, 3, 5, 2, S_WAIT, 0, 0, 0, 0, 0);
        add(1, 0, 3, 5, 2, S_WAIT, 1, 0, 0, 0, 0);
        add(1, 0, 3, 5, 2, S_WAIT, 2, 0, 0, 0, 0);
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 5; c++)
                add(1, 0, 3, 5, 2, S_RUN, c, f, c == 0, c == 4, (f == 1) && (c == 4));
        for (int k = 0; k < 3; k++)
            add(1, 0, 3, 5, 2, S_IDLE, 0, 0, 0, 0, 0);
        add(0, 0, 3, 5, 2, S_IDLE, 0, 0, 0, 0, 0);
        // ---- table: zero delay, infinite burst, length 4 ----
        add(1, 0, 0, 4, 0, S_ARM, 0, 0, 0, 0, 0);
        for (int n = 0; n < 17; n++)
            add(1, n == 0, 0, 4, 0, S_RUN, n % 4, n / 4, (n % 4) == 0, (n % 4) == 3, 0);
        add(0, 0, 0, 4, 0, S_IDLE, 0, 0, 0, 0, 0);
        // ---- table: length 1, burst 3, extra syncs while running ----
        add(1, 0, 0, 1, 3, S_ARM, 0, 0, 0, 0, 0);
        for (int f = 0; f < 3; f++)
            add(1, 1, 0, 1, 3, S_RUN, 0, f, 1, 1, f == 2);
        add(1, 0, 0, 1, 3, S_IDLE, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 3, S_IDLE, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 3, S_IDLE, 0, 0, 0, 0, 0);

        // ---- reset ----
        cfg_delay = '0; cfg_length = '0; cfg_burst = '0;
        rst = 1'b1; bus.tdd_enable = 1'b0; bus.tdd_sync = 1'b0;
        bus.asy_startup_delay = '0; bus.asy_frame_length = '0; bus.asy_burst_count = '0;
        @(negedge clk);
        cyc(1, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "reset_state");

        // ---- table-driven vectors ----
        for (int k = 0; k < tbl.size(); k++) begin
            cfg_delay  = tbl[k].dl;
            cfg_length = tbl[k].ln;
            cfg_burst  = tbl[k].bu;
            cyc(0, tbl[k].en, tbl[k].sync, tbl[k].st, int'(tbl[k].cnt), int'(tbl[k].idx),
                tbl[k].fs, tbl[k].eof, tbl[k].bd, $sformatf("tbl[%0d]", k));
        end

        // ---- enable drop mid-frame (length 10) ----
        cfg_delay = 0; cfg_length = 10; cfg_burst = 0;
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "drop_arm");
        cyc(0, 1, 1, S_RUN, 0, 0, 1, 0, 0, "drop_run0");
        for (int c = 1; c <= 6; c++)
            cyc(0, 1, 0, S_RUN, c, 0, 0, 0, 0, $sformatf("drop_run%0d", c));
        cyc(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "drop_idle");
        cyc(0, 0, 1, S_IDLE, 0, 0, 0, 0, 0, "drop_idle_sync");
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "drop_rearm");
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "drop_wait_sync");
        cyc(0, 1, 1, S_RUN, 0, 0, 1, 0, 0, "drop_fresh_sync");
        cyc(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "drop_exit");

        // ---- reset mid-frame with enable held high ----
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "rst_arm");
        cyc(0, 1, 1, S_RUN, 0, 0, 1, 0, 0, "rst_run0");
        cyc(0, 1, 0, S_RUN, 1, 0, 0, 0, 0, "rst_run1");
        cyc(0, 1, 0, S_RUN, 2, 0, 0, 0, 0, "rst_run2");
        cyc(1, 1, 0, S_IDLE, 0, 0, 0, 0, 0, "rst_mid_frame");
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "rst_edge_reg_cleared");
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "rst_armed_hold");
        cyc(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "rst_exit");

        // ---- config isolation: length 5 -> 8 while running ----
        cfg_delay = 0; cfg_length = 5; cfg_burst = 0;
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "cfg_arm");
        cyc(0, 1, 1, S_RUN, 0, 0, 1, 0, 0, "cfg_run");
        cfg_length = 8;
        for (int n = 1; n < 11; n++)
            cyc(0, 1, 0, S_RUN, n % 5, n / 5, (n % 5) == 0, (n % 5) == 4, 0,
                $sformatf("cfg_len5_%0d", n));
        cyc(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "cfg_idle");
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "cfg_rearm");
        cyc(0, 1, 1, S_RUN, 0, 0, 1, 0, 0, "cfg_run8");
        for (int n = 1; n < 9; n++)
            cyc(0, 1, 0, S_RUN, n % 8, n / 8, (n % 8) == 0, (n % 8) == 7, 0,
                $sformatf("cfg_len8_%0d", n));
        cyc(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "cfg_exit");

        // ---- sync at counter 4 in the second frame (length 10) ----
        cfg_delay = 0; cfg_length = 10; cfg_burst = 0;
        cyc(0, 1, 0, S_ARM, 0, 0, 0, 0, 0, "rs_arm");
        cyc(0, 1, 1, S_RUN, 0, 0, 1, 0, 0, "rs_run");
        for (int n = 1; n < 15; n++)
            cyc(0, 1, 0, S_RUN, n % 10, n / 10, (n % 10) == 0, (n % 10) == 9, 0,
                $sformatf("rs_pre_%0d", n));
`ifdef AXI_TDD_FRAME_SEQ_RESYNC_EN
        cyc(0, 1, 1, S_RUN, 0, 1, 1, 0, 0, "rs_restart");
        for (int c = 1; c < 10; c++)
            cyc(0, 1, 0, S_RUN, c, 1, 0, c == 9, 0, $sformatf("rs_post_%0d", c));
        cyc(0, 1, 0, S_RUN, 0, 2, 1, 0, 0, "rs_next_frame");
`else
        cyc(0, 1, 1, S_RUN, 5, 1, 0, 0, 0, "rs_ignored");
        for (int c = 6; c < 10; c++)
            cyc(0, 1, 0, S_RUN, c, 1, 0, c == 9, 0, $sformatf("rs_post_%0d", c));
        cyc(0, 1, 0, S_RUN, 0, 2, 1, 0, 0, "rs_next_frame");
`endif
        cyc(0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, "rs_exit");

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_tdd_frame_seq.md
Name: axi_tdd_frame_seq

Overview:
- Frame sequencer that consumes the TDD sync pulse and sequences TDD frames for the channel/timing logic downstream.
- Flow: arm on enable, wait for sync, apply a startup delay, then run a programmable number of fixed-length frames (or run forever).
- Outputs a state code, a frame-relative counter, a frame index and frame start/end strobes. Channel on/off comparators key off these outputs.

Parameters:
- CNT_WIDTH, 32, width of startup delay, frame length and frame counter.
- BURST_WIDTH, 32, width of burst count and frame index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tdd_enable  in  1  sequencer enable, level
- tdd_sync  in  1  one-cycle sync pulse from sync generator
- asy_startup_delay  in  CNT_WIDTH  cycles from sync to first frame
- asy_frame_length  in  CNT_WIDTH  frame length in cycles
- asy_burst_count  in  BURST_WIDTH  frames per burst; 0 = infinite
- tdd_cstate  out  2  0 IDLE, 1 ARMED, 2 WAITING, 3 RUNNING
- tdd_counter  out  CNT_WIDTH  delay/frame counter
- tdd_frame_idx  out  BURST_WIDTH  index of current frame in burst
- tdd_frame_start  out  1  pulse, first cycle of each frame
- tdd_endof_frame  out  1  pulse, last cycle of each frame
- tdd_burst_done  out  1  pulse, last cycle of final frame of a finite burst

Behaviour:
- Reset: state IDLE; tdd_counter, tdd_frame_idx = 0; all strobes 0; enable-edge register 0.
- All outputs are decoded from registered state, counter and index. There is no combinational path from any input to any output.
- Config latch: asy_* values are registered into internal copies only on the IDLE->ARMED transition. They are held constant until the sequencer next leaves IDLE.
- IDLE -> ARMED: on a tdd_enable rising edge (high now, low on the previous cycle). A level-high enable after burst completion does not re-arm.
- ARMED:
  - counter held 0.
  - On tdd_sync: go to WAITING if delay != 0, else go directly to RUNNING with counter 0.
- WAITING:
  - counter increments by 1 each cycle.
  - When counter == delay-1: go to RUNNING, counter <= 0, frame_idx <= 0.
- RUNNING:
  - counter increments by 1 each cycle.
  - tdd_frame_start = 1 when counter == 0.
  - tdd_endof_frame = 1 when counter == frame_length-1 (modular arithmetic; length 0 means 2^CNT_WIDTH cycles). On that cycle counter <= 0.
  - If burst != 0 and frame_idx == burst-1: also assert tdd_burst_done and go to IDLE, frame_idx <= 0.
  - Otherwise frame_idx <= frame_idx+1, wrapping modulo 2^BURST_WIDTH in infinite mode.
- frame_length == 1: frame_start and endof_frame are both high every RUNNING cycle.
- tdd_enable low in any state: next state IDLE, counter and frame_idx <= 0, no strobes on that transition. Enable low takes priority over sync and frame end in the same cycle.
- tdd_sync outside ARMED is ignored unless the optional feature is compiled in.
- rst has priority over everything. Mid-frame reset returns all outputs to their reset values on the next edge.

Optional Feature:
- Macro: AXI_TDD_FRAME_SEQ_RESYNC_EN.
- Defined:
  - tdd_sync in WAITING or RUNNING restarts timing: state RUNNING, counter <= 0, frame_idx unchanged. The restarted frame asserts frame_start.
  - The interrupted frame asserts no endof_frame and no burst_done.
  - If sync coincides with the last cycle of a frame, endof_frame and burst handling occur first. A burst-done exit to IDLE wins over resync.
- Undefined: sync honoured only in ARMED; no extra logic is generated.

Test Plan:
- Basic burst:
  - Stimulus: rst then enable=1, delay=3, length=5, burst=2; sync pulse at cycle T.
  - Required: WAITING counts 0..2; frame_start at T+4 and T+9; endof_frame at T+8 and T+13; burst_done at T+13; then IDLE and stays IDLE while enable remains 1.
- Zero delay, infinite burst:
  - Stimulus: delay=0, length=4, burst=0, sync.
  - Required: RUNNING next cycle; endof_frame every 4 cycles; frame_idx 0,1,2,... with no exit.
- Enable drop mid-frame:
  - Stimulus: length=10; deassert enable at counter=6.
  - Required: next cycle state=0, counter=0, no endof_frame; re-enable waits for a fresh sync.
- Config isolation:
  - Stimulus: change asy_frame_length from 5 to 8 while RUNNING.
  - Required: frames stay 5 long until the next IDLE->ARMED transition.
- length=1 / sync ignored:
  - Stimulus: length=1, burst=3; extra sync pulses during RUNNING (macro off).
  - Required: frame_start and endof_frame high 3 consecutive cycles, burst_done on the third; extra syncs have no effect.
- Resync (macro on):
  - Stimulus: length=10; sync at counter=4.
  - Required: counter=0 next cycle with frame_start, no endof_frame, frame_idx unchanged.
